// File: rtl/pll_lock_sequencer.sv
// Bring-up and supervision sequencer for an iCE40 SB_PLL40_CORE.
// Runs on the PLL reference clock. It pulses RESETB and waits for the
// synchronised LOCK to hold steady before it releases the downstream reset.
// If lock is lost it re-arms the PLL. Repeated lock timeouts latch a fault.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES        = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       clock_ready,
    output logic       domain_reset,
    output logic       fault,
    output logic [7:0] lost_lock_count,
    output logic [2:0] state
);

    // The shared timer must reach (largest cycle parameter - 1) without wrapping.
    localparam int unsigned MAX_A   = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES
                                                                          : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retries_q, retries_d;
    logic [7:0]       lost_q, lost_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_resetb_q, pll_resetb_d;
    logic             clock_ready_q, clock_ready_d;
    logic             domain_reset_q, domain_reset_d;
    logic             fault_q, fault_d;
    logic [7:0]       retries_inc;

    // Two-flop synchroniser for the asynchronous PLL LOCK output.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let both flops sample the old values on the same edge,
            // so this forms a true two-stage shift.
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, timer, retry and lost-lock bookkeeping.
    always_comb begin
        // NOTE: each variable gets a default first, so no path can leave it unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = '0;
        retries_d   = retries_q;
        lost_d      = lost_q;
        retries_inc = retries_q + 8'd1;

        unique case (state_q)
            ST_IDLE: begin
                retries_d = '0;
                if (enable) state_d = ST_RESET;
            end
            ST_RESET: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
                end
            end
            ST_STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = ST_RUN;
                    retries_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_RESET;
                    lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable wins over everything. A drop that coincides with a lock loss is not counted.
        if (!enable) begin
            state_d   = ST_IDLE;
            retries_d = '0;
            lost_d    = lost_q;
        end

        // Each state measures its own dwell time from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    // Output decode from the next state. The registered outputs then change on the same edge as the state.
    always_comb begin
        pll_resetb_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
        clock_ready_d  = (state_d == ST_RUN);
        domain_reset_d = (state_d != ST_RUN);
        fault_d        = (state_d == ST_FAULT);
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            retries_q      <= '0;
            lost_q         <= '0;
            pll_resetb_q   <= 1'b0;
            clock_ready_q  <= 1'b0;
            domain_reset_q <= 1'b1;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retries_q      <= retries_d;
            lost_q         <= lost_d;
            pll_resetb_q   <= pll_resetb_d;
            clock_ready_q  <= clock_ready_d;
            domain_reset_q <= domain_reset_d;
            fault_q        <= fault_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign clock_ready     = clock_ready_q;
    assign domain_reset    = domain_reset_q;
    assign fault           = fault_q;
    assign lost_lock_count = lost_q;
    assign state           = state_q;

endmodule
